// File: rtl/req_arbiter_12.sv
// Sequential arbiter for N requesters: fixed or round-robin pick, registered one-hot grant held until release or hold timeout.
// Latency: req sampled in IDLE -> gnt next cycle; each grant is followed by a GAP and an IDLE cycle; no backpressure, waiting requesters simply hold req.
`timescale 1ns/1ps
module req_arbiter_12 #(
    parameter int N        = 12,
    parameter int IDW      = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N - 1);
    localparam logic [N-1:0]   ONE      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic           busy_nxt;
    logic           timeout_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [CW-1:0]  hold_cnt, hold_cnt_nxt;

    logic [N-1:0]   lo_mask;
    logic [N-1:0]   masked;
    logic [N-1:0]   search;
    logic [IDW-1:0] win;
    logic           owner_req;
    logic           expired;

    // Round-robin: indices at or below ptr are searched first (highest first);
    // if none of them request, the highest request overall wins, which is the wrapped part.
    always_comb begin
        lo_mask = '0;
        for (int i = 0; i < N; i++) begin
            lo_mask[i] = (i <= int'(ptr));
        end
        masked = req & lo_mask;
        search = ((RR_EN != 0) && (masked != '0)) ? masked : req;
        win    = '0;
        for (int i = 0; i < N; i++) begin
            if (search[i]) begin
                win = IDW'(i);
            end
        end
    end

    assign owner_req = |(req & gnt);
    assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = ONE << win;
                    gnt_id_nxt   = win;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = {{(CW-1){1'b0}}, 1'b1};
                    if (RR_EN != 0) begin
                        ptr_nxt = (win == '0) ? PTR_RST : (win - 1'b1);
                    end
                end
            end
            GRANT: begin
                // A release on the expiry edge counts as a normal release, so it is tested first.
                if (!owner_req || expired) begin
                    state_nxt   = GAP;
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '1;
                    busy_nxt    = 1'b0;
                    timeout_nxt = owner_req;
                end else if (hold_cnt != {CW{1'b1}}) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '1;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '1;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= PTR_RST;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_req_arbiter_12.sv
// Bench for req_arbiter_12: four instances (RR/16, fixed/16, RR/4, RR/3) driven per cycle,
// checked against hand-built vector tables, directed sequences and a cycle model.
`timescale 1ns/1ps
module tb_req_arbiter_12;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0][11:0] req = '0;
    logic [3:0][11:0] gnt;
    logic [3:0][3:0]  gid;
    logic [3:0]       busy;
    logic [3:0]       tmo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    req_arbiter_12 #(.N(12), .IDW(4), .RR_EN(1), .MAX_HOLD(16)) u_d (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .gnt(gnt[0]),
        .gnt_id(gid[0]), .busy(busy[0]), .timeout(tmo[0]));
    req_arbiter_12 #(.N(12), .IDW(4), .RR_EN(0), .MAX_HOLD(16)) u_f (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .gnt(gnt[1]),
        .gnt_id(gid[1]), .busy(busy[1]), .timeout(tmo[1]));
    req_arbiter_12 #(.N(12), .IDW(4), .RR_EN(1), .MAX_HOLD(4)) u_t (
        .clk(clk), .reset_n(reset_n), .req(req[2]), .gnt(gnt[2]),
        .gnt_id(gid[2]), .busy(busy[2]), .timeout(tmo[2]));
    req_arbiter_12 #(.N(12), .IDW(4), .RR_EN(1), .MAX_HOLD(3)) u_r (
        .clk(clk), .reset_n(reset_n), .req(req[3]), .gnt(gnt[3]),
        .gnt_id(gid[3]), .busy(busy[3]), .timeout(tmo[3]));

    // Abstract model: st 0=idle 1=owned 2=gap; owner/ptr as plain integers.
    typedef struct {
        int st;
        int owner;
        int ptr;
        int cnt;
        bit tmo;
        bit rr;
        int mh;
    } mdl_t;

    typedef struct {
        int          d;
        logic [11:0] r;
        logic [11:0] g;
        logic [3:0]  id;
        logic        b;
        logic        t;
    } vec_t;

    mdl_t m[4];

    function automatic mdl_t mreset(bit rr, int mh);
        mdl_t n;
        n.st = 0; n.owner = 0; n.ptr = 11; n.cnt = 0; n.tmo = 1'b0;
        n.rr = rr; n.mh = mh;
        return n;
    endfunction

    function automatic int pick(mdl_t s, logic [11:0] r);
        int idx;
        for (int k = 0; k < 12; k++) begin
            idx = s.rr ? (s.ptr - k + 12) % 12 : 11 - k;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic [11:0] r);
        mdl_t n;
        int w;
        n = s;
        n.tmo = 1'b0;
        if (s.st == 0) begin
            if (r != 12'h000) begin
                w = pick(s, r);
                n.st = 1; n.owner = w; n.cnt = 1;
                if (s.rr) n.ptr = (w + 11) % 12;
            end
        end else if (s.st == 1) begin
            if (!r[s.owner]) n.st = 2;
            else if (s.mh != 0 && s.cnt == s.mh) begin
                n.st = 2; n.tmo = 1'b1;
            end else n.cnt = s.cnt + 1;
        end else begin
            n.st = 0;
        end
        return n;
    endfunction

    function automatic logic [31:0] mexp(mdl_t s);
        logic [11:0] g;
        logic [3:0]  id;
        logic        b;
        g = '0; id = 4'hF; b = 1'b0;
        if (s.st == 1) begin
            g[s.owner] = 1'b1; id = 4'(s.owner); b = 1'b1;
        end
        return {14'd0, g, id, b, s.tmo};
    endfunction

    function automatic logic [31:0] obs(int d);
        return {14'd0, gnt[d], gid[d], busy[d], tmo[d]};
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, got, exp);
        end
    endtask

    // Called at a falling edge: drive, let the DUTs sample, check at the next falling edge.
    task automatic step(input logic [3:0][11:0] r);
        req = r;
        @(posedge clk);
        for (int d = 0; d < 4; d++) m[d] = mstep(m[d], req[d]);
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk("model", d, obs(d), mexp(m[d]));
    endtask

    task automatic one(input int d, input logic [11:0] r);
        logic [3:0][11:0] v;
        v = '0;
        v[d] = r;
        step(v);
    endtask

    localparam logic [31:0] RST_VAL = {14'd0, 12'h000, 4'hF, 1'b0, 1'b0};

    initial begin
        vec_t tbl[23];
        int   ord[3];
        logic [3:0][11:0] rv;
        int   k;
        int   ph;
        logic [31:0] e;

        // Single request on u_d (RR, 16): 5 grant cycles, then GAP and IDLE.
        tbl[0]  = '{0, 12'h010, 12'h010, 4'h4, 1'b1, 1'b0};
        tbl[1]  = '{0, 12'h010, 12'h010, 4'h4, 1'b1, 1'b0};
        tbl[2]  = '{0, 12'h010, 12'h010, 4'h4, 1'b1, 1'b0};
        tbl[3]  = '{0, 12'h010, 12'h010, 4'h4, 1'b1, 1'b0};
        tbl[4]  = '{0, 12'h010, 12'h010, 4'h4, 1'b1, 1'b0};
        tbl[5]  = '{0, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[6]  = '{0, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[7]  = '{0, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        // Timeout boundary on u_t (MAX_HOLD=4): release on 4th cycle, then held to timeout.
        tbl[8]  = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[9]  = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[10] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[11] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[12] = '{2, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[13] = '{2, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[14] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[15] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[16] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[17] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[18] = '{2, 12'h020, 12'h000, 4'hF, 1'b0, 1'b1};
        tbl[19] = '{2, 12'h020, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[20] = '{2, 12'h020, 12'h020, 4'h5, 1'b1, 1'b0};
        tbl[21] = '{2, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};
        tbl[22] = '{2, 12'h000, 12'h000, 4'hF, 1'b0, 1'b0};

        m[0] = mreset(1'b1, 16);
        m[1] = mreset(1'b0, 16);
        m[2] = mreset(1'b1, 4);
        m[3] = mreset(1'b1, 3);

        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk("reset", d, obs(d), RST_VAL);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            one(tbl[i].d, tbl[i].r);
            chk("vec", tbl[i].d, obs(tbl[i].d),
                {14'd0, tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].t});
        end

        // Fixed priority: 7 beats 5 and 0 every round even after dropping and re-raising.
        for (int rnd = 0; rnd < 3; rnd++) begin
            one(1, 12'h0A1);
            chk("fix_win", 1, 32'(gid[1]), 32'd7);
            one(1, 12'h0A1);
            chk("fix_hold", 1, 32'(gid[1]), 32'd7);
            one(1, 12'h021);
            chk("fix_rel", 1, 32'(busy[1]), 32'd0);
            one(1, 12'h0A1);
            chk("fix_gap", 1, 32'(gid[1]), 32'hF);
        end

        // Round-robin fairness with MAX_HOLD=3: 11,7,0 repeating, 3 grant + timeout GAP + IDLE.
        ord[0] = 11; ord[1] = 7; ord[2] = 0;
        for (int c = 0; c < 30; c++) begin
            one(3, 12'h881);
            ph = c % 5;
            if (ph < 3)       e = {27'd0, 4'(ord[(c / 5) % 3]), 1'b1};
            else              e = {27'd0, 4'hF, 1'b0};
            chk("rr_order", 3, {27'd0, gid[3], busy[3]}, e);
            chk("rr_tmo", 3, 32'(tmo[3]), (ph == 3) ? 32'd1 : 32'd0);
        end

        // Wrap: winner 0 moves ptr to 11, so 11 wins over 0 next time.
        one(0, 12'h001);
        chk("wrap_first", 0, 32'(gid[0]), 32'd0);
        one(0, 12'h001);
        one(0, 12'h000);
        one(0, 12'h801);
        one(0, 12'h801);
        chk("wrap_win", 0, 32'(gid[0]), 32'd11);
        one(0, 12'h000);
        for (int c = 0; c < 10; c++) begin
            one(0, 12'h000);
            chk("no_req", 0, {27'd0, gid[0], busy[0]}, {27'd0, 4'hF, 1'b0});
        end

        // Asynchronous reset in the middle of a grant.
        one(0, 12'h800);
        one(0, 12'h800);
        chk("pre_rst", 0, obs(0), {14'd0, 12'h800, 4'hB, 1'b1, 1'b0});
        #2;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) chk("rst_mid", d, obs(d), RST_VAL);
        m[0] = mreset(1'b1, 16);
        m[1] = mreset(1'b0, 16);
        m[2] = mreset(1'b1, 4);
        m[3] = mreset(1'b1, 3);
        req = '0;
        @(negedge clk);
        chk("rst_hold", 0, obs(0), RST_VAL);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            one(0, 12'h000);
            chk("rst_idle", 0, obs(0), RST_VAL);
        end

        // Randomised traffic against the model on all four instances.
        rv = '0;
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 2) == 0) begin
                    k = int'($urandom_range(0, 11));
                    rv[d][k] = ~rv[d][k];
                end
                if ($urandom_range(0, 19) == 0) rv[d] = '0;
            end
            step(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end
endmodule
